biriscv_npc_wide: RTL and testbench

Parametrised next-PC predictor for the biRISC-V fetch stage, generalising the two-lane predictor to FETCH_LANES instruction slots per fetch block. It combines a fully-associative BTB with valid bits, a configurable-width BHT (optional gshare), and a bounded return-address stack with commit/speculative pointers and overflow/underflow tracking. It sits between the fetch PC register and the branch-resolution interface from the execute/writeback stages.

---
 rtl/biriscv_npc_wide_pkg.sv | 24 ++
 rtl/biriscv_npc_ras.sv | 93 +++++++++
 rtl/biriscv_npc_wide.sv | 201 ++++++++++++++++++++
 tb/tb_biriscv_npc_wide.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/biriscv_npc_wide_pkg.sv
// Shared constants and helpers for the wide next-PC predictor: BHT reset value,
// BTB replacement LFSR, RAS empty marker and the BTB branch-class record.
package biriscv_npc_wide_pkg;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] LFSR_SEED   = 16'h0001;
  localparam logic [31:0] RAS_INVALID = 32'h0000_0001;

  typedef struct packed {
    logic is_call;
    logic is_ret;
    logic is_jmp;
  } br_class_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Weakly-taken midpoint of a ctr_w-bit saturating counter.
  function automatic int unsigned bht_reset_val(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/biriscv_npc_ras.sv
// Return-address stack with committed and speculative pointer/depth pairs over
// one shared circular storage; a restore copies the committed view into speculative.
module biriscv_npc_ras
  import biriscv_npc_wide_pkg::*;
#(
  parameter int NUM_RAS_ENTRIES   = 8,
  parameter int NUM_RAS_ENTRIES_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        restore_i,
  input  logic        commit_push_i,
  input  logic        commit_pop_i,
  input  logic [31:0] commit_addr_i,
  input  logic        spec_push_i,
  input  logic        spec_pop_i,
  input  logic [31:0] spec_addr_i,
  output logic        valid_o,
  output logic [31:0] top_o
);

  localparam logic [NUM_RAS_ENTRIES_W:0] DEPTH_MAX = (NUM_RAS_ENTRIES_W + 1)'(NUM_RAS_ENTRIES);

  logic [31:0]                  stack_q [NUM_RAS_ENTRIES];
  logic [NUM_RAS_ENTRIES_W-1:0] cptr_q, cptr_d, sptr_q, sptr_d;
  logic [NUM_RAS_ENTRIES_W:0]   cdep_q, cdep_d, sdep_q, sdep_d;
  logic                         wr_en;
  logic [NUM_RAS_ENTRIES_W-1:0] wr_idx;
  logic [31:0]                  wr_data;

  function automatic logic [NUM_RAS_ENTRIES_W-1:0] ptr_inc(input logic [NUM_RAS_ENTRIES_W-1:0] p);
    return (p == NUM_RAS_ENTRIES_W'(NUM_RAS_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NUM_RAS_ENTRIES_W-1:0] ptr_dec(input logic [NUM_RAS_ENTRIES_W-1:0] p);
    return (p == '0) ? NUM_RAS_ENTRIES_W'(NUM_RAS_ENTRIES - 1) : p - 1'b1;
  endfunction

  // A push at full depth wraps onto the oldest slot; a pop at depth 0 is a no-op.
  always_comb begin
    cptr_d  = cptr_q;
    cdep_d  = cdep_q;
    sptr_d  = sptr_q;
    sdep_d  = sdep_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = commit_addr_i;
    if (commit_push_i) begin
      cptr_d  = ptr_inc(cptr_q);
      cdep_d  = (cdep_q == DEPTH_MAX) ? cdep_q : cdep_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = cptr_d;
    end else if (commit_pop_i && (cdep_q != '0)) begin
      cptr_d = ptr_dec(cptr_q);
      cdep_d = cdep_q - 1'b1;
    end
    if (restore_i) begin
      sptr_d = cptr_d;
      sdep_d = cdep_d;
    end else if (spec_push_i) begin
      sptr_d  = ptr_inc(sptr_q);
      sdep_d  = (sdep_q == DEPTH_MAX) ? sdep_q : sdep_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = sptr_d;
      wr_data = spec_addr_i;
    end else if (spec_pop_i && (sdep_q != '0)) begin
      sptr_d = ptr_dec(sptr_q);
      sdep_d = sdep_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cptr_q <= '0;
      cdep_q <= '0;
      sptr_q <= '0;
      sdep_q <= '0;
    end else begin
      cptr_q <= cptr_d;
      cdep_q <= cdep_d;
      sptr_q <= sptr_d;
      sdep_q <= sdep_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) stack_q[wr_idx] <= wr_data;
  end

  assign valid_o = (sdep_q != '0);
  assign top_o   = valid_o ? stack_q[sptr_q] : RAS_INVALID;

endmodule

// File: rtl/biriscv_npc_wide.sv
// Next-PC predictor for a FETCH_LANES-wide fetch block: fully-associative BTB,
// saturating-counter BHT (optional gshare) and a speculative return-address stack.
module biriscv_npc_wide
  import biriscv_npc_wide_pkg::*;
#(
  parameter int FETCH_LANES       = 2,
  parameter int FETCH_LANES_W     = 1,
  parameter int NUM_BTB_ENTRIES   = 32,
  parameter int NUM_BTB_ENTRIES_W = 5,
  parameter int NUM_BHT_ENTRIES   = 512,
  parameter int NUM_BHT_ENTRIES_W = 9,
  parameter int BHT_CTR_W         = 2,
  parameter int NUM_RAS_ENTRIES   = 8,
  parameter int NUM_RAS_ENTRIES_W = 3,
  parameter int GSHARE_ENABLE     = 0,
  parameter int BHT_ENABLE        = 1,
  parameter int RAS_ENABLE        = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   invalidate_i,
  input  logic                   branch_request_i,
  input  logic                   branch_is_taken_i,
  input  logic                   branch_is_not_taken_i,
  input  logic [31:0]            branch_source_i,
  input  logic [31:0]            branch_pc_i,
  input  logic                   branch_is_call_i,
  input  logic                   branch_is_ret_i,
  input  logic                   branch_is_jmp_i,
  input  logic [31:0]            pc_f_i,
  input  logic                   pc_accept_i,
  output logic [31:0]            next_pc_f_o,
  output logic [FETCH_LANES-1:0] next_taken_f_o
);

  localparam logic [31:0]          LANE_MASK = 32'((64'd1 << (2 + FETCH_LANES_W)) - 64'd1);
  localparam logic [BHT_CTR_W-1:0] BHT_RST   = BHT_CTR_W'(bht_reset_val(BHT_CTR_W));

  typedef logic [NUM_BTB_ENTRIES_W-1:0] btb_idx_t;
  typedef logic [NUM_BHT_ENTRIES_W-1:0] bht_idx_t;

  logic [NUM_BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [31:0]                btb_pc_q     [NUM_BTB_ENTRIES];
  logic [31:0]                btb_target_q [NUM_BTB_ENTRIES];
  br_class_t                  btb_cls_q    [NUM_BTB_ENTRIES];
  logic [BHT_CTR_W-1:0]       bht_q        [NUM_BHT_ENTRIES];
  bht_idx_t                   ghr_c_q, ghr_c_d, ghr_s_q, ghr_s_d;
  logic [15:0]                lfsr_q, lfsr_d;

  logic [31:0]          base_w;
  logic [FETCH_LANES_W-1:0] ofs_w;
  logic [31:0]          lane_addr_w [FETCH_LANES];
  btb_idx_t             lane_idx_w  [FETCH_LANES];
  br_class_t            lane_cls_w  [FETCH_LANES];
  logic [BHT_CTR_W-1:0] lane_ctr_w  [FETCH_LANES];
  logic [FETCH_LANES-1:0] lane_hit_w, lane_tkn_w;
  bht_idx_t             ghr_lookup_w;
  logic                 sel_valid_w;
  logic [31:0]          sel_addr_w, sel_target_w;
  br_class_t            sel_cls_w;
  logic                 ras_nonempty_w, ras_valid_w;
  logic [31:0]          ras_top_w;

  logic                 wr_hit_w, wr_free_w, btb_wr_en, btb_tgt_en;
  btb_idx_t             wr_hit_idx_w, wr_free_idx_w, btb_wr_idx;
  logic                 bht_wr_en;
  bht_idx_t             bht_wr_idx;
  logic [BHT_CTR_W-1:0] bht_wr_val;

  function automatic logic [BHT_CTR_W-1:0] ctr_inc(input logic [BHT_CTR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [BHT_CTR_W-1:0] ctr_dec(input logic [BHT_CTR_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  assign ras_valid_w  = (RAS_ENABLE != 0) && ras_nonempty_w;
  assign ghr_lookup_w = (GSHARE_ENABLE != 0) ? ghr_s_q : '0;

  // Per-lane lookup; descending scans make the lowest matching entry / lane win.
  always_comb begin
    base_w         = pc_f_i & ~LANE_MASK;
    ofs_w          = pc_f_i[2 +: FETCH_LANES_W];
    lane_hit_w     = '0;
    lane_tkn_w     = '0;
    sel_valid_w    = 1'b0;
    sel_addr_w     = base_w;
    sel_target_w   = '0;
    sel_cls_w      = '0;
    next_taken_f_o = '0;
    for (int l = 0; l < FETCH_LANES; l++) begin
      lane_addr_w[l] = base_w + 32'(4 * l);
      lane_idx_w[l]  = '0;
      for (int e = NUM_BTB_ENTRIES - 1; e >= 0; e--) begin
        if (btb_valid_q[e] && (btb_pc_q[e] == lane_addr_w[l])) begin
          lane_hit_w[l] = 1'b1;
          lane_idx_w[l] = btb_idx_t'(e);
        end
      end
      lane_hit_w[l] = lane_hit_w[l] && (FETCH_LANES_W'(l) >= ofs_w);
      lane_cls_w[l] = btb_cls_q[lane_idx_w[l]];
      lane_ctr_w[l] = bht_q[lane_addr_w[l][2 +: NUM_BHT_ENTRIES_W] ^ ghr_lookup_w];
      lane_tkn_w[l] = lane_hit_w[l] &&
                      (lane_cls_w[l].is_jmp ||
                       (lane_cls_w[l].is_ret && ras_valid_w) ||
                       (!lane_cls_w[l].is_call && !lane_cls_w[l].is_ret && !lane_cls_w[l].is_jmp &&
                        (BHT_ENABLE != 0) && lane_ctr_w[l][BHT_CTR_W-1]));
    end
    for (int l = FETCH_LANES - 1; l >= 0; l--) begin
      if (lane_tkn_w[l]) begin
        sel_valid_w       = 1'b1;
        sel_addr_w        = lane_addr_w[l];
        sel_target_w      = btb_target_q[lane_idx_w[l]];
        sel_cls_w         = lane_cls_w[l];
        next_taken_f_o    = '0;
        next_taken_f_o[l] = 1'b1;
      end
    end
    if (!sel_valid_w)                          next_pc_f_o = base_w + 32'(4 * FETCH_LANES);
    else if (sel_cls_w.is_ret && ras_valid_w)  next_pc_f_o = ras_top_w;
    else                                       next_pc_f_o = sel_target_w;
  end

  // Resolved-branch update of BTB, BHT, histories and replacement LFSR.
  always_comb begin
    wr_hit_w      = 1'b0;
    wr_hit_idx_w  = '0;
    wr_free_w     = 1'b0;
    wr_free_idx_w = '0;
    for (int e = NUM_BTB_ENTRIES - 1; e >= 0; e--) begin
      if (btb_valid_q[e] && (btb_pc_q[e] == branch_source_i)) begin
        wr_hit_w     = 1'b1;
        wr_hit_idx_w = btb_idx_t'(e);
      end
      if (!btb_valid_q[e]) begin
        wr_free_w     = 1'b1;
        wr_free_idx_w = btb_idx_t'(e);
      end
    end
    btb_wr_idx  = wr_hit_w ? wr_hit_idx_w : (wr_free_w ? wr_free_idx_w : lfsr_q[NUM_BTB_ENTRIES_W-1:0]);
    btb_wr_en   = branch_request_i && !invalidate_i;
    btb_tgt_en  = btb_wr_en && (!wr_hit_w || branch_is_taken_i);
    btb_valid_d = btb_valid_q;
    if (invalidate_i)   btb_valid_d = '0;
    else if (btb_wr_en) btb_valid_d[btb_wr_idx] = 1'b1;
    lfsr_d = (btb_wr_en && !wr_hit_w && !wr_free_w) ? lfsr_next(lfsr_q) : lfsr_q;

    bht_wr_en  = (BHT_ENABLE != 0) && (branch_is_taken_i || branch_is_not_taken_i);
    bht_wr_idx = branch_source_i[2 +: NUM_BHT_ENTRIES_W] ^ ((GSHARE_ENABLE != 0) ? ghr_c_q : '0);
    bht_wr_val = branch_is_taken_i ? ctr_inc(bht_q[bht_wr_idx]) : ctr_dec(bht_q[bht_wr_idx]);

    ghr_c_d = (branch_is_taken_i || branch_is_not_taken_i) ?
              {ghr_c_q[NUM_BHT_ENTRIES_W-2:0], branch_is_taken_i} : ghr_c_q;
    ghr_s_d = ghr_s_q;
    if (branch_request_i)                ghr_s_d = {ghr_c_q[NUM_BHT_ENTRIES_W-2:0], branch_is_taken_i};
    else if (pc_accept_i && |lane_hit_w) ghr_s_d = {ghr_s_q[NUM_BHT_ENTRIES_W-2:0], sel_valid_w};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btb_valid_q <= '0;
      lfsr_q      <= LFSR_SEED;
      ghr_c_q     <= '0;
      ghr_s_q     <= '0;
      for (int i = 0; i < NUM_BHT_ENTRIES; i++) bht_q[i] <= BHT_RST;
    end else begin
      btb_valid_q <= btb_valid_d;
      lfsr_q      <= lfsr_d;
      ghr_c_q     <= ghr_c_d;
      ghr_s_q     <= ghr_s_d;
      if (bht_wr_en) bht_q[bht_wr_idx] <= bht_wr_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && btb_wr_en) begin
      btb_pc_q[btb_wr_idx]  <= branch_source_i;
      btb_cls_q[btb_wr_idx] <= '{is_call: branch_is_call_i, is_ret: branch_is_ret_i, is_jmp: branch_is_jmp_i};
      if (btb_tgt_en) btb_target_q[btb_wr_idx] <= branch_pc_i;
    end
  end

  biriscv_npc_ras #(
    .NUM_RAS_ENTRIES   (NUM_RAS_ENTRIES),
    .NUM_RAS_ENTRIES_W (NUM_RAS_ENTRIES_W)
  ) u_ras (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .restore_i     (branch_request_i),
    .commit_push_i ((RAS_ENABLE != 0) && branch_request_i && branch_is_call_i),
    .commit_pop_i  ((RAS_ENABLE != 0) && branch_request_i && branch_is_ret_i && !branch_is_call_i),
    .commit_addr_i (branch_source_i + 32'd4),
    .spec_push_i   ((RAS_ENABLE != 0) && pc_accept_i && sel_valid_w && sel_cls_w.is_call),
    .spec_pop_i    ((RAS_ENABLE != 0) && pc_accept_i && sel_valid_w && sel_cls_w.is_ret && !sel_cls_w.is_call),
    .spec_addr_i   (sel_addr_w + 32'd4),
    .valid_o       (ras_nonempty_w),
    .top_o         (ras_top_w)
  );

endmodule

// File: tb/tb_biriscv_npc_wide.sv
// Scoreboarded bench: a 2-lane and a 4-lane predictor share the branch-resolution
// inputs; each prediction request queues its expected result for the monitor.
module tb_biriscv_npc_wide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv = 1'b0, breq = 1'b0, btk = 1'b0, bnt = 1'b0;
  logic        bcall = 1'b0, bret = 1'b0, bjmp = 1'b0;
  logic [31:0] bsrc = '0, bpc = '0;
  logic [31:0] pc_a = 32'h1000, pc_b = 32'h1000;
  logic        acc_a = 1'b0, acc_b = 1'b0;
  logic [31:0] npc_a, npc_b;
  logic [1:0]  tk_a;
  logic [3:0]  tk_b;

  typedef struct {
    int          dut;
    logic [31:0] pc;
    logic [3:0]  tk;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic chk = 1'b0, fin_req = 1'b0, fin_done = 1'b0;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  biriscv_npc_wide #(.FETCH_LANES(2), .FETCH_LANES_W(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .invalidate_i(inv), .branch_request_i(breq),
    .branch_is_taken_i(btk), .branch_is_not_taken_i(bnt), .branch_source_i(bsrc),
    .branch_pc_i(bpc), .branch_is_call_i(bcall), .branch_is_ret_i(bret),
    .branch_is_jmp_i(bjmp), .pc_f_i(pc_a), .pc_accept_i(acc_a),
    .next_pc_f_o(npc_a), .next_taken_f_o(tk_a));

  biriscv_npc_wide #(.FETCH_LANES(4), .FETCH_LANES_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .invalidate_i(inv), .branch_request_i(breq),
    .branch_is_taken_i(btk), .branch_is_not_taken_i(bnt), .branch_source_i(bsrc),
    .branch_pc_i(bpc), .branch_is_call_i(bcall), .branch_is_ret_i(bret),
    .branch_is_jmp_i(bjmp), .pc_f_i(pc_b), .pc_accept_i(acc_b),
    .next_pc_f_o(npc_b), .next_taken_f_o(tk_b));

  // Monitor: samples on the falling edge whenever a prediction request is live.
  initial begin
    exp_t        e;
    logic [31:0] act_pc;
    logic [3:0]  act_tk;
    forever begin
      @(negedge clk);
      if (chk) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: prediction presented with no expected entry queued");
        end else begin
          e      = sb_q.pop_front();
          act_pc = (e.dut == 0) ? npc_a : npc_b;
          act_tk = (e.dut == 0) ? {2'b00, tk_a} : tk_b;
          if ((act_pc !== e.pc) || (act_tk !== e.tk)) begin
            failures++;
            $display("FAIL %s: got next_pc=%h taken=%b, expected next_pc=%h taken=%b",
                     e.name, act_pc, act_tk, e.pc, e.tk);
          end
        end
      end
      if (fin_req && !fin_done) begin
        checks++;
        if (sb_q.size() != 0) begin
          failures++;
          $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        fin_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before end of stimulus");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic br(input logic [31:0] src, input logic [31:0] tgt, input logic tk, input logic nt,
                    input logic call, input logic ret, input logic jmp, input logic invl);
    bsrc = src; bpc = tgt; btk = tk; bnt = nt;
    bcall = call; bret = ret; bjmp = jmp; inv = invl; breq = 1'b1;
    step();
    breq = 1'b0; btk = 1'b0; bnt = 1'b0; bcall = 1'b0; bret = 1'b0; bjmp = 1'b0; inv = 1'b0;
  endtask

  task automatic pred(input int dut, input logic [31:0] pc, input logic acc,
                      input logic [31:0] epc, input logic [3:0] etk, input string nm);
    exp_t e;
    if (dut == 0) begin pc_a = pc; acc_a = acc; end
    else          begin pc_b = pc; acc_b = acc; end
    e.dut = dut; e.pc = epc; e.tk = etk; e.name = nm;
    sb_q.push_back(e);
    chk = 1'b1;
    step();
    chk = 1'b0; acc_a = 1'b0; acc_b = 1'b0;
  endtask

  initial begin
    step();
    do_reset();
    pred(0, 32'h1000, 1'b0, 32'h1008, 4'b0000, "rst_a");
    pred(1, 32'h100C, 1'b0, 32'h1010, 4'b0000, "rst_b");

    // Unconditional jump learned at lane 1 of block 0x1000.
    br(32'h1004, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pred(0, 32'h1000, 1'b0, 32'h2000, 4'b0010, "jmp_a_lane1");
    pred(0, 32'h1004, 1'b0, 32'h2000, 4'b0010, "jmp_a_mid");
    pred(0, 32'h1008, 1'b0, 32'h1010, 4'b0000, "jmp_a_next_blk");
    pred(1, 32'h1000, 1'b0, 32'h2000, 4'b0010, "jmp_b_lane1");
    pred(1, 32'h1008, 1'b0, 32'h1010, 4'b0000, "jmp_b_inactive");

    // Invalidate beats a simultaneous BTB write.
    br(32'h1004, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    pred(0, 32'h1000, 1'b0, 32'h1008, 4'b0000, "invalidate");

    // Conditional branch: counter 2 -> 1 -> 0 -> 0 (saturate) -> 1 -> 2.
    do_reset();
    br(32'h1000, 32'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pred(0, 32'h1000, 1'b0, 32'h1008, 4'b0000, "bht_ctr1");
    br(32'h1000, 32'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pred(0, 32'h1000, 1'b0, 32'h1008, 4'b0000, "bht_ctr0");
    br(32'h1000, 32'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pred(0, 32'h1000, 1'b0, 32'h1008, 4'b0000, "bht_sat0");
    br(32'h1000, 32'h1800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pred(0, 32'h1000, 1'b0, 32'h1008, 4'b0000, "bht_up1");
    br(32'h1000, 32'h1800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pred(0, 32'h1000, 1'b0, 32'h1800, 4'b0001, "bht_up2_taken");

    // Committed RAS overflow: 9 calls into an 8-deep stack, then 9 returns.
    do_reset();
    br(32'h2000, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++)
      br(32'h100 + 32'(4 * k), 32'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) pred(0, 32'h2000, 1'b0, 32'h124 - 32'(4 * k), 4'b0001, $sformatf("ras_pop%0d", k));
      else       pred(0, 32'h2000, 1'b0, 32'h5000, 4'b0001, "ras_underflow_btb");
      br(32'h2000, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Speculative RAS on the 4-lane predictor, then restore from committed.
    do_reset();
    br(32'h3000, 32'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    br(32'h4008, 32'h6000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pred(1, 32'h4008, 1'b0, 32'h6000, 4'b0100, "sras_empty");
    pred(1, 32'h3000, 1'b1, 32'h4000, 4'b0001, "sras_call");
    pred(1, 32'h4008, 1'b0, 32'h3004, 4'b0100, "sras_ret_noacc");
    pred(1, 32'h4008, 1'b1, 32'h3004, 4'b0100, "sras_ret_acc");
    pred(1, 32'h4008, 1'b0, 32'h6000, 4'b0100, "sras_popped");
    pred(1, 32'h3000, 1'b1, 32'h4000, 4'b0001, "sras_call2");
    br(32'h7000, 32'h7100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pred(1, 32'h4008, 1'b0, 32'h6000, 4'b0100, "sras_restore");

    // BTB replacement: fill all 32 entries, LFSR victims are entry 1 then entry 0.
    do_reset();
    for (int k = 0; k < 32; k++)
      br(32'h8000 + 32'(8 * k), 32'h9000 + 32'(8 * k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pred(0, 32'h80F8, 1'b0, 32'h90F8, 4'b0001, "btb_full_last");
    br(32'hA000, 32'hB000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pred(0, 32'h8008, 1'b0, 32'h8010, 4'b0000, "lfsr_victim1");
    pred(0, 32'h8000, 1'b0, 32'h9000, 4'b0001, "lfsr_keep0");
    pred(0, 32'hA000, 1'b0, 32'hB000, 4'b0001, "lfsr_new1");
    br(32'hC000, 32'hD000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pred(0, 32'h8000, 1'b0, 32'h8008, 4'b0000, "lfsr_victim0");
    pred(0, 32'hC000, 1'b0, 32'hD000, 4'b0001, "lfsr_new0");
    pred(0, 32'hA000, 1'b0, 32'hB000, 4'b0001, "lfsr_keep1");

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) step();
    if (!fin_done) begin
      $display("FAIL final_drain: monitor did not complete within cycle budget");
      $fatal(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
